cpu_datapath: RTL and testbench

- Register/ALU datapath for the 8-bit CPU; the responder to the control unit's strobes (MUX_sel, ALU_op, *_load, *_inc, AB_sel, memory_WE).
- Holds PC, AR, TH/TL, IR, DR, AC and Z/C flags, computes ALU results, and drives the external memory port.
- Returns Instruction, flag_z and flag_c to the control unit.
- Rising-edge registers; the control unit advances on the opposite edge, so the strobes are stable at each rising edge.

---
 rtl/cpu_datapath_pkg.sv | 28 ++
 rtl/cpu_datapath_if.sv | 46 ++++
 rtl/cpu_datapath_alu.sv | 40 ++++
 rtl/cpu_datapath.sv | 105 ++++++++++
 tb/tb_cpu_datapath.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared encodings for the 8-bit CPU: ALU operations and bus-source selects.
// The control unit imports the same package so both sides agree on the codes.
package cpu_datapath_pkg;

    typedef enum logic [3:0] {
        ALU_ZERO = 4'd0,
        ALU_PASS = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOT  = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        MUX_ACC = 2'd0,
        MUX_DR  = 2'd1,
        MUX_PC  = 2'd2,
        MUX_MEM = 2'd3
    } mux_sel_e;

    // Only ADD and SUB produce a meaningful carry/borrow flag.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Control-strobe, memory-port and status bundle between control unit and datapath.
// master = control unit / memory side, slave = datapath.
interface cpu_datapath_if #(
    parameter int DATA_W = 8
);
    logic [1:0]          MUX_sel;
    logic [3:0]          ALU_op;
    logic                memory_WE;
    logic                AR_load;
    logic                AR_inc;
    logic                PC_load;
    logic                PC_inc;
    logic                AC_load;
    logic                ZC_load;
    logic                IR_load;
    logic                DR_load;
    logic                TL_load;
    logic                TH_load;
    logic                AB_sel;
    logic [DATA_W-1:0]   mem_rdata;
    logic [2*DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_we;
    logic [DATA_W-1:0]   Instruction;
    logic                flag_z;
    logic                flag_c;
    logic [2*DATA_W-1:0] dbg_pc;
    logic [DATA_W-1:0]   dbg_ac;

    modport master (
        output MUX_sel, ALU_op, memory_WE, AR_load, AR_inc, PC_load, PC_inc,
               AC_load, ZC_load, IR_load, DR_load, TL_load, TH_load, AB_sel,
               mem_rdata,
        input  mem_addr, mem_wdata, mem_we, Instruction, flag_z, flag_c,
               dbg_pc, dbg_ac
    );

    modport slave (
        input  MUX_sel, ALU_op, memory_WE, AR_load, AR_inc, PC_load, PC_inc,
               AC_load, ZC_load, IR_load, DR_load, TL_load, TH_load, AB_sel,
               mem_rdata,
        output mem_addr, mem_wdata, mem_we, Instruction, flag_z, flag_c,
               dbg_pc, dbg_ac
    );

endinterface

// File: rtl/cpu_datapath_alu.sv
// cpu_alu: combinational ALU with a 9-bit internal result so carry/borrow falls out of bit DATA_W.
module cpu_alu
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic              c_in,
    output logic [DATA_W-1:0] res,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] res_w;
    logic [DATA_W:0] cin_w;

    assign cin_w = {{DATA_W{1'b0}}, c_in};

    // Subtraction wraps modulo 2^(DATA_W+1), so a borrow shows up as the top bit.
    always_comb begin
        res_w = '0;
        case (op)
            ALU_PASS: res_w = {1'b0, b};
            ALU_ADD:  res_w = {1'b0, a} + {1'b0, b} + cin_w;
            ALU_SUB:  res_w = {1'b0, a} - {1'b0, b} - cin_w;
            ALU_AND:  res_w = {1'b0, a & b};
            ALU_OR:   res_w = {1'b0, a | b};
            ALU_XOR:  res_w = {1'b0, a ^ b};
            ALU_NOT:  res_w = {1'b0, ~a};
            default:  res_w = '0;
        endcase
    end

    assign res = res_w[DATA_W-1:0];
    assign z   = (res_w[DATA_W-1:0] == '0);
    assign c   = is_arith(op) ? res_w[DATA_W] : 1'b0;

endmodule

// File: rtl/cpu_datapath.sv
// Register/ALU datapath of the 8-bit CPU: PC, AR, TH/TL, IR, DR, AC, Z/C and the memory port.
// Optional CPU_DATAPATH_ADC_EN feeds the C flag into ADD/SUB for multi-byte arithmetic.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int                  DATA_W   = 8,
    parameter logic [2*DATA_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    cpu_datapath_if.slave bus_if
);

    localparam int ADDR_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DATA_W-1:0] th_q, th_d, tl_q, tl_d;
    logic [DATA_W-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
    logic              z_q, z_d, c_q, c_d;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    logic              alu_z, alu_c, alu_c_in;

    always_comb begin
        bus = ac_q;
        case (bus_if.MUX_sel)
            MUX_ACC: bus = ac_q;
            MUX_DR:  bus = dr_q;
            MUX_PC:  bus = pc_q[DATA_W-1:0];
            MUX_MEM: bus = bus_if.mem_rdata;
            default: bus = ac_q;
        endcase
    end

`ifdef CPU_DATAPATH_ADC_EN
    assign alu_c_in = c_q;
`else
    assign alu_c_in = 1'b0;
`endif

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (ac_q),
        .b    (bus),
        .op   (bus_if.ALU_op),
        .c_in (alu_c_in),
        .res  (alu_res),
        .z    (alu_z),
        .c    (alu_c)
    );

    // AR_load with AB_sel=1 deliberately reads pc_q, i.e. the PC before this edge's update.
    always_comb begin
        pc_d = pc_q;
        if (bus_if.PC_load)     pc_d = {th_q, tl_q};
        else if (bus_if.PC_inc) pc_d = pc_q + ADDR_ONE;

        ar_d = ar_q;
        if (bus_if.AR_load)     ar_d = bus_if.AB_sel ? pc_q : {th_q, tl_q};
        else if (bus_if.AR_inc) ar_d = ar_q + ADDR_ONE;

        th_d = bus_if.TH_load ? bus : th_q;
        tl_d = bus_if.TL_load ? bus : tl_q;
        ir_d = bus_if.IR_load ? bus : ir_q;
        dr_d = bus_if.DR_load ? bus : dr_q;
        ac_d = bus_if.AC_load ? alu_res : ac_q;
        z_d  = bus_if.ZC_load ? alu_z : z_q;
        c_d  = bus_if.ZC_load ? alu_c : c_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            ar_q <= '0;
            th_q <= '0;
            tl_q <= '0;
            ir_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ar_q <= ar_d;
            th_q <= th_d;
            tl_q <= tl_d;
            ir_q <= ir_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            z_q  <= z_d;
            c_q  <= c_d;
        end
    end

    assign bus_if.mem_addr    = ar_q;
    assign bus_if.mem_wdata   = bus;
    assign bus_if.mem_we      = bus_if.memory_WE;
    assign bus_if.Instruction = ir_q;
    assign bus_if.flag_z      = z_q;
    assign bus_if.flag_c      = c_q;
    assign bus_if.dbg_pc      = pc_q;
    assign bus_if.dbg_ac      = ac_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized strobes against an arithmetic model.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    logic clk = 1'b0;
    logic rst;

    cpu_datapath_if #(.DATA_W(8)) bus_if ();

    cpu_datapath #(.DATA_W(8), .RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_pc, m_ar;
    logic [7:0]  m_th, m_tl, m_ir, m_dr, m_ac;
    logic        m_z, m_c;

    function automatic logic [7:0] model_bus();
        case (bus_if.MUX_sel)
            2'd0:    return m_ac;
            2'd1:    return m_dr;
            2'd2:    return m_pc[7:0];
            default: return bus_if.mem_rdata;
        endcase
    endfunction

    // Reference ALU in plain integer arithmetic.
    task automatic model_alu(input int op, input int a, input int b, input int cin,
                             output logic [7:0] res, output logic z, output logic c);
        int r;
        c = 1'b0;
        case (op)
            1:       r = b;
            2:       begin r = a + b + cin; c = (r > 255); end
            3:       begin r = a - b - cin; c = (r < 0);   end
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a ^ b;
            7:       r = 255 - a;
            default: r = 0;
        endcase
        res = 8'(r & 255);
        z   = (res == 8'h00);
    endtask

    task automatic model_step();
        logic [7:0] b, res;
        logic       z, c;
        int         cin, pc_n, ar_n;
        if (rst) begin
            m_pc = 16'h0000; m_ar = 16'h0000;
            m_th = 8'h00; m_tl = 8'h00; m_ir = 8'h00; m_dr = 8'h00; m_ac = 8'h00;
            m_z = 1'b0; m_c = 1'b0;
        end else begin
            b = model_bus();
`ifdef CPU_DATAPATH_ADC_EN
            cin = int'(m_c);
`else
            cin = 0;
`endif
            model_alu(int'(bus_if.ALU_op), int'(m_ac), int'(b), cin, res, z, c);
            pc_n = int'(m_pc);
            if (bus_if.PC_load)     pc_n = int'(m_th) * 256 + int'(m_tl);
            else if (bus_if.PC_inc) pc_n = (int'(m_pc) + 1) % 65536;
            ar_n = int'(m_ar);
            if (bus_if.AR_load)     ar_n = bus_if.AB_sel ? int'(m_pc) : int'(m_th) * 256 + int'(m_tl);
            else if (bus_if.AR_inc) ar_n = (int'(m_ar) + 1) % 65536;
            m_pc = 16'(pc_n);
            m_ar = 16'(ar_n);
            if (bus_if.TH_load) m_th = b;
            if (bus_if.TL_load) m_tl = b;
            if (bus_if.IR_load) m_ir = b;
            if (bus_if.DR_load) m_dr = b;
            if (bus_if.AC_load) m_ac = res;
            if (bus_if.ZC_load) begin m_z = z; m_c = c; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        rst              = 1'b0;
        bus_if.MUX_sel   = 2'd0;
        bus_if.ALU_op    = 4'd0;
        bus_if.memory_WE = 1'b0;
        bus_if.AR_load   = 1'b0;
        bus_if.AR_inc    = 1'b0;
        bus_if.PC_load   = 1'b0;
        bus_if.PC_inc    = 1'b0;
        bus_if.AC_load   = 1'b0;
        bus_if.ZC_load   = 1'b0;
        bus_if.IR_load   = 1'b0;
        bus_if.DR_load   = 1'b0;
        bus_if.TL_load   = 1'b0;
        bus_if.TH_load   = 1'b0;
        bus_if.AB_sel    = 1'b0;
        bus_if.mem_rdata = 8'h00;
    endtask

    task automatic load_ac(input logic [7:0] v);
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = v;
        bus_if.ALU_op = ALU_PASS; bus_if.AC_load = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic load_pc(input logic [15:0] v);
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = v[15:8]; bus_if.TH_load = 1'b1;
        tick();
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = v[7:0]; bus_if.TL_load = 1'b1;
        tick();
        clear_strobes();
        bus_if.PC_load = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset();
        load_ac(8'h5A);
        load_pc(16'h1234);
        n_checks++; if (bus_if.dbg_pc !== 16'h1234) $display("[TB] FAIL pre_reset_pc: got %h expected %h", bus_if.dbg_pc, 16'h1234); else n_pass++;
        n_checks++; if (bus_if.dbg_ac !== 8'h5A) $display("[TB] FAIL pre_reset_ac: got %h expected %h", bus_if.dbg_ac, 8'h5A); else n_pass++;
        rst = 1'b1; bus_if.PC_inc = 1'b1; bus_if.AC_load = 1'b1; bus_if.ZC_load = 1'b1;
        bus_if.AR_inc = 1'b1; bus_if.IR_load = 1'b1; bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'hEE;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_pc !== 16'h0000) $display("[TB] FAIL reset_pc: got %h expected %h", bus_if.dbg_pc, 16'h0000); else n_pass++;
        n_checks++; if (bus_if.dbg_ac !== 8'h00) $display("[TB] FAIL reset_ac: got %h expected %h", bus_if.dbg_ac, 8'h00); else n_pass++;
        n_checks++; if ({bus_if.flag_z, bus_if.flag_c} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {bus_if.flag_z, bus_if.flag_c}); else n_pass++;
        n_checks++; if (bus_if.mem_addr !== 16'h0000) $display("[TB] FAIL reset_addr: got %h expected %h", bus_if.mem_addr, 16'h0000); else n_pass++;
        n_checks++; if (bus_if.Instruction !== 8'h00) $display("[TB] FAIL reset_ir: got %h expected %h", bus_if.Instruction, 8'h00); else n_pass++;
    endtask

    task automatic test_add_carry();
        load_ac(8'hF0);
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h20; bus_if.ALU_op = ALU_ADD;
        bus_if.AC_load = 1'b1; bus_if.ZC_load = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_ac !== 8'h10) $display("[TB] FAIL add_ac: got %h expected %h", bus_if.dbg_ac, 8'h10); else n_pass++;
        n_checks++; if (bus_if.flag_c !== 1'b1) $display("[TB] FAIL add_c: got %b expected 1", bus_if.flag_c); else n_pass++;
        n_checks++; if (bus_if.flag_z !== 1'b0) $display("[TB] FAIL add_z: got %b expected 0", bus_if.flag_z); else n_pass++;
        // Flags-only update clears C so the SUB below is a plain subtract in every build.
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h10; bus_if.ALU_op = ALU_PASS; bus_if.ZC_load = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_ac !== 8'h10) $display("[TB] FAIL zc_only_ac: got %h expected %h", bus_if.dbg_ac, 8'h10); else n_pass++;
        n_checks++; if (bus_if.flag_c !== 1'b0) $display("[TB] FAIL zc_only_c: got %b expected 0", bus_if.flag_c); else n_pass++;
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h10; bus_if.ALU_op = ALU_SUB;
        bus_if.AC_load = 1'b1; bus_if.ZC_load = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_ac !== 8'h00) $display("[TB] FAIL sub_ac: got %h expected %h", bus_if.dbg_ac, 8'h00); else n_pass++;
        n_checks++; if ({bus_if.flag_z, bus_if.flag_c} !== 2'b10) $display("[TB] FAIL sub_flags: got %b expected 10", {bus_if.flag_z, bus_if.flag_c}); else n_pass++;
    endtask

    task automatic test_jump();
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h12; bus_if.TH_load = 1'b1;
        tick();
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h34; bus_if.TL_load = 1'b1;
        tick();
        clear_strobes();
        bus_if.PC_load = 1'b1; bus_if.PC_inc = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_pc !== 16'h1234) $display("[TB] FAIL jump_pc: got %h expected %h", bus_if.dbg_pc, 16'h1234); else n_pass++;
        bus_if.AR_load = 1'b1; bus_if.AB_sel = 1'b1; bus_if.PC_inc = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.mem_addr !== 16'h1234) $display("[TB] FAIL jump_ar: got %h expected %h", bus_if.mem_addr, 16'h1234); else n_pass++;
        n_checks++; if (bus_if.dbg_pc !== 16'h1235) $display("[TB] FAIL jump_pc_inc: got %h expected %h", bus_if.dbg_pc, 16'h1235); else n_pass++;
    endtask

    task automatic test_wrap();
        load_pc(16'hFFFF);
        bus_if.PC_inc = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_pc !== 16'h0000) $display("[TB] FAIL pc_wrap: got %h expected %h", bus_if.dbg_pc, 16'h0000); else n_pass++;
        bus_if.AR_load = 1'b1; bus_if.AB_sel = 1'b0;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.mem_addr !== 16'hFFFF) $display("[TB] FAIL ar_load_tt: got %h expected %h", bus_if.mem_addr, 16'hFFFF); else n_pass++;
        bus_if.AR_inc = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.mem_addr !== 16'h0000) $display("[TB] FAIL ar_wrap: got %h expected %h", bus_if.mem_addr, 16'h0000); else n_pass++;
    endtask

    task automatic test_store();
        load_ac(8'hA5);
        bus_if.MUX_sel = MUX_ACC; bus_if.memory_WE = 1'b1; bus_if.DR_load = 1'b1;
        #1;
        n_checks++; if (bus_if.mem_we !== 1'b1) $display("[TB] FAIL store_we: got %b expected 1", bus_if.mem_we); else n_pass++;
        n_checks++; if (bus_if.mem_wdata !== 8'hA5) $display("[TB] FAIL store_wdata: got %h expected %h", bus_if.mem_wdata, 8'hA5); else n_pass++;
        tick();
        clear_strobes();
        bus_if.MUX_sel = MUX_DR;
        #1;
        n_checks++; if (bus_if.mem_we !== 1'b0) $display("[TB] FAIL idle_we: got %b expected 0", bus_if.mem_we); else n_pass++;
        n_checks++; if (bus_if.mem_wdata !== 8'hA5) $display("[TB] FAIL dr_value: got %h expected %h", bus_if.mem_wdata, 8'hA5); else n_pass++;
        clear_strobes();
    endtask

    task automatic test_back_to_back();
        clear_strobes();
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h77;
        bus_if.TH_load = 1'b1; bus_if.TL_load = 1'b1; bus_if.IR_load = 1'b1; bus_if.DR_load = 1'b1;
        tick();
        clear_strobes();
        bus_if.PC_load = 1'b1; bus_if.MUX_sel = MUX_DR;
        #1;
        n_checks++; if (bus_if.mem_wdata !== 8'h77) $display("[TB] FAIL multi_dr: got %h expected %h", bus_if.mem_wdata, 8'h77); else n_pass++;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_pc !== 16'h7777) $display("[TB] FAIL multi_pc: got %h expected %h", bus_if.dbg_pc, 16'h7777); else n_pass++;
        n_checks++; if (bus_if.Instruction !== 8'h77) $display("[TB] FAIL multi_ir: got %h expected %h", bus_if.Instruction, 8'h77); else n_pass++;
        bus_if.MUX_sel = MUX_PC;
        #1;
        n_checks++; if (bus_if.mem_wdata !== 8'h77) $display("[TB] FAIL bus_pc_low: got %h expected %h", bus_if.mem_wdata, 8'h77); else n_pass++;
        clear_strobes();
    endtask

    task automatic test_adc();
        logic [7:0] exp_ac;
`ifdef CPU_DATAPATH_ADC_EN
        exp_ac = 8'h03;
`else
        exp_ac = 8'h02;
`endif
        load_ac(8'hF0);
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h20; bus_if.ALU_op = ALU_ADD;
        bus_if.AC_load = 1'b1; bus_if.ZC_load = 1'b1;
        tick();
        load_ac(8'h01);
        n_checks++; if (bus_if.flag_c !== 1'b1) $display("[TB] FAIL adc_c_held: got %b expected 1", bus_if.flag_c); else n_pass++;
        bus_if.MUX_sel = MUX_MEM; bus_if.mem_rdata = 8'h01; bus_if.ALU_op = ALU_ADD; bus_if.AC_load = 1'b1;
        tick();
        clear_strobes();
        n_checks++; if (bus_if.dbg_ac !== exp_ac) $display("[TB] FAIL adc_ac: got %h expected %h", bus_if.dbg_ac, exp_ac); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst              = ($urandom_range(0, 49) == 0);
            bus_if.MUX_sel   = 2'($urandom_range(0, 3));
            bus_if.ALU_op    = 4'($urandom_range(0, 15));
            bus_if.memory_WE = ($urandom_range(0, 2) == 0);
            bus_if.AR_load   = ($urandom_range(0, 3) == 0);
            bus_if.AR_inc    = ($urandom_range(0, 2) == 0);
            bus_if.PC_load   = ($urandom_range(0, 4) == 0);
            bus_if.PC_inc    = ($urandom_range(0, 2) == 0);
            bus_if.AC_load   = ($urandom_range(0, 1) == 0);
            bus_if.ZC_load   = ($urandom_range(0, 1) == 0);
            bus_if.IR_load   = ($urandom_range(0, 2) == 0);
            bus_if.DR_load   = ($urandom_range(0, 2) == 0);
            bus_if.TL_load   = ($urandom_range(0, 2) == 0);
            bus_if.TH_load   = ($urandom_range(0, 2) == 0);
            bus_if.AB_sel    = ($urandom_range(0, 1) == 0);
            bus_if.mem_rdata = 8'($urandom_range(0, 255));
            #1;
            n_checks++; if (bus_if.mem_wdata !== model_bus()) $display("[TB] FAIL rnd_wdata[%0d]: got %h expected %h", i, bus_if.mem_wdata, model_bus()); else n_pass++;
            n_checks++; if (bus_if.mem_we !== bus_if.memory_WE) $display("[TB] FAIL rnd_we[%0d]: got %b expected %b", i, bus_if.mem_we, bus_if.memory_WE); else n_pass++;
            tick();
            n_checks++; if (bus_if.dbg_pc !== m_pc) $display("[TB] FAIL rnd_pc[%0d]: got %h expected %h", i, bus_if.dbg_pc, m_pc); else n_pass++;
            n_checks++; if (bus_if.mem_addr !== m_ar) $display("[TB] FAIL rnd_ar[%0d]: got %h expected %h", i, bus_if.mem_addr, m_ar); else n_pass++;
            n_checks++; if (bus_if.Instruction !== m_ir) $display("[TB] FAIL rnd_ir[%0d]: got %h expected %h", i, bus_if.Instruction, m_ir); else n_pass++;
            n_checks++; if (bus_if.dbg_ac !== m_ac) $display("[TB] FAIL rnd_ac[%0d]: got %h expected %h", i, bus_if.dbg_ac, m_ac); else n_pass++;
            n_checks++; if ({bus_if.flag_z, bus_if.flag_c} !== {m_z, m_c}) $display("[TB] FAIL rnd_flags[%0d]: got %b expected %b", i, {bus_if.flag_z, bus_if.flag_c}, {m_z, m_c}); else n_pass++;
        end
        clear_strobes();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_strobes();
        rst = 1'b1;
        tick();
        tick();
        clear_strobes();
        test_reset();
        test_add_carry();
        test_jump();
        test_wrap();
        test_store();
        test_back_to_back();
        test_adc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
